// File: rtl/kv_packet_issuer.sv
// kv_packet_issuer: byte-serial frame collector feeding a transaction FIFO issued over valid/ready
module kv_packet_issuer #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     tick_in,
    input  logic                     rst_n,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic [1:0]               signal,
    output logic                     transact_kind,
    output logic [KEY_W-1:0]         key,
    output logic [VAL_W-1:0]         transact_value,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic                     bad_hdr,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int KB = KEY_W / 8;
    localparam int VB = VAL_W / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(KB > VB ? KB : VB) + 1;
    localparam int EW = KEY_W + VAL_W + 1;
    typedef enum logic [1:0] {S_HDR, S_KEY, S_VAL, S_PUSH} state_t;
    state_t            state_q, state_d;
    logic              kind_q, kind_d, bad_q, bad_d;
    logic [KEY_W-1:0]  key_sr_q, key_sr_d;
    logic [VAL_W-1:0]  val_sr_q, val_sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       count_q, count_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     head;
    logic              accept, push, pop;
    always_comb begin
        accept   = byte_valid && state_q != S_PUSH;
        push     = state_q == S_PUSH && count_q != (AW+1)'(DEPTH);
        pop      = count_q != '0 && issue_ready;
        state_d  = state_q;
        kind_d   = kind_q;
        key_sr_d = key_sr_q;
        val_sr_d = val_sr_q;
        cnt_d    = cnt_q;
        bad_d    = 1'b0;
        case (state_q)
            S_HDR: if (accept) begin
                if (byte_in == 8'hA1 || byte_in == 8'hA2) begin
                    kind_d  = byte_in[1];
                    cnt_d   = '0;
                    state_d = S_KEY;
                end else begin
                    bad_d = 1'b1;
                end
            end
            S_KEY: if (accept) begin
                key_sr_d = (key_sr_q << 8) | KEY_W'(byte_in);
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(KB - 1)) begin
                    cnt_d    = '0;
                    state_d  = kind_q ? S_VAL : S_PUSH;
                    val_sr_d = kind_q ? val_sr_q : '0;
                end
            end
            S_VAL: if (accept) begin
                val_sr_d = (val_sr_q << 8) | VAL_W'(byte_in);
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(VB - 1)) begin
                    cnt_d   = '0;
                    state_d = S_PUSH;
                end
            end
            default: state_d = push ? S_HDR : S_PUSH;
        endcase
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge tick_in) begin
        if (!rst_n) begin
            state_q  <= S_HDR;
            kind_q   <= 1'b0;
            key_sr_q <= '0;
            val_sr_q <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            key_sr_q <= key_sr_d;
            val_sr_q <= val_sr_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge tick_in) begin
        if (push) mem_q[wr_q] <= {kind_q, key_sr_q, val_sr_q};
    end
    assign head           = mem_q[rd_q];
    assign issue_valid    = count_q != '0;
    assign transact_kind  = issue_valid && head[EW-1];
    assign key            = issue_valid ? head[EW-2:VAL_W] : '0;
    assign transact_value = issue_valid ? head[VAL_W-1:0] : '0;
    assign signal         = issue_valid ? {transact_kind, ~transact_kind} : 2'd0;
    assign byte_ready     = state_q != S_PUSH;
    assign bad_hdr        = bad_q;
    assign fifo_count     = count_q;
endmodule

// File: tb/tb_kv_packet_issuer.sv
// tb_kv_packet_issuer: frame-level reference model plus directed frames for two parameter builds
module tb_kv_packet_issuer;
    localparam int KW = 32;
    localparam int VW = 32;
    localparam int D  = 4;
    logic        tick_in = 1'b0;
    logic        rst_n = 1'b0, byte_valid = 1'b0, issue_ready = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready, transact_kind, issue_valid, bad_hdr;
    logic [1:0]  signal;
    logic [KW-1:0] key;
    logic [VW-1:0] transact_value;
    logic [2:0]  fifo_count;
    logic        w_rst_n = 1'b0, w_byte_valid = 1'b0, w_issue_ready = 1'b0;
    logic [7:0]  w_byte_in = 8'h00;
    logic        w_byte_ready, w_kind, w_issue_valid, w_bad_hdr;
    logic [1:0]  w_signal;
    logic [63:0] w_key;
    logic [15:0] w_value;
    logic [2:0]  w_fifo_count;
    always #5 tick_in = ~tick_in;
    kv_packet_issuer #(.KEY_W(KW), .VAL_W(VW), .DEPTH(D)) dut (
        .tick_in(tick_in), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .signal(signal), .transact_kind(transact_kind), .key(key),
        .transact_value(transact_value), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .bad_hdr(bad_hdr), .fifo_count(fifo_count));
    kv_packet_issuer #(.KEY_W(64), .VAL_W(16), .DEPTH(4)) dut_w (
        .tick_in(tick_in), .rst_n(w_rst_n), .byte_in(w_byte_in), .byte_valid(w_byte_valid),
        .byte_ready(w_byte_ready), .signal(w_signal), .transact_kind(w_kind), .key(w_key),
        .transact_value(w_value), .issue_valid(w_issue_valid), .issue_ready(w_issue_ready),
        .bad_hdr(w_bad_hdr), .fifo_count(w_fifo_count));
    typedef struct {
        logic          kind;
        logic [KW-1:0] k;
        logic [VW-1:0] v;
    } ent_t;
    ent_t       mq[$];
    logic [7:0] frame[$];
    ent_t       pend;
    bit         pending = 0, exp_bad = 0;
    int         checks = 0, errors = 0;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask
    // Frame-level model: a completed frame waits one edge, then enters the queue if it had room
    always begin : model
        bit acc, pu, po;
        @(posedge tick_in);
        if (!rst_n) begin
            mq.delete();
            frame.delete();
            pending = 0;
            exp_bad = 0;
        end else begin
            acc = byte_valid && !pending;
            po  = mq.size() != 0 && issue_ready;
            pu  = pending && mq.size() < D;
            exp_bad = 0;
            if (po) void'(mq.pop_front());
            if (pu) begin
                mq.push_back(pend);
                pending = 0;
            end
            if (acc) begin
                if (frame.size() == 0) begin
                    if (byte_in == 8'hA1 || byte_in == 8'hA2) frame.push_back(byte_in);
                    else exp_bad = 1;
                end else begin
                    frame.push_back(byte_in);
                    if (frame.size() == (frame[0] == 8'hA2 ? 1 + KW/8 + VW/8 : 1 + KW/8)) begin
                        pend.kind = frame[0] == 8'hA2;
                        pend.k = '0;
                        pend.v = '0;
                        for (int i = 1; i <= KW/8; i++) pend.k = {pend.k[KW-9:0], frame[i]};
                        if (pend.kind)
                            for (int i = 1 + KW/8; i <= KW/8 + VW/8; i++) pend.v = {pend.v[VW-9:0], frame[i]};
                        pending = 1;
                        frame.delete();
                    end
                end
            end
        end
        #1;
        chk("m_byte_ready", byte_ready, !pending);
        chk("m_bad_hdr", bad_hdr, exp_bad);
        chk("m_fifo_count", fifo_count, mq.size());
        chk("m_issue_valid", issue_valid, mq.size() != 0);
        chk("m_signal", signal, mq.size() == 0 ? 0 : 1 + mq[0].kind);
        chk("m_kind", transact_kind, mq.size() == 0 ? 1'b0 : mq[0].kind);
        chk("m_key", key, mq.size() == 0 ? '0 : mq[0].k);
        chk("m_value", transact_value, mq.size() == 0 ? '0 : mq[0].v);
    end
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge tick_in);
        end
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 200) begin
            @(negedge tick_in);
            n++;
        end
        if (n >= 200) chk("byte_timeout", 1'b0, 1'b1);
        @(negedge tick_in);
    endtask
    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] k, input logic [31:0] v);
        send_byte(hdr, 0);
        for (int i = 0; i < 4; i++) send_byte(k[31-8*i -: 8], 0);
        if (hdr == 8'hA2) for (int i = 0; i < 4; i++) send_byte(v[31-8*i -: 8], 0);
        byte_valid = 1'b0;
    endtask
    task automatic wsend_byte(input logic [7:0] b, input int gap);
        int n = 0;
        if (gap > 0) begin
            w_byte_valid = 1'b0;
            repeat (gap) @(negedge tick_in);
        end
        w_byte_in = b;
        w_byte_valid = 1'b1;
        while (!w_byte_ready && n < 200) begin
            @(negedge tick_in);
            n++;
        end
        if (n >= 200) chk("w_byte_timeout", 1'b0, 1'b1);
        @(negedge tick_in);
    endtask
    task automatic wsend_frame(input logic [7:0] hdr, input logic [63:0] k, input logic [15:0] v, input int gmax);
        wsend_byte(hdr, $urandom_range(0, gmax));
        for (int i = 0; i < 8; i++) wsend_byte(k[63-8*i -: 8], $urandom_range(0, gmax));
        if (hdr == 8'hA2) for (int i = 0; i < 2; i++) wsend_byte(v[15-8*i -: 8], $urandom_range(0, gmax));
        w_byte_valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(negedge tick_in);
        chk("rst_signal", signal, 2'd0);
        chk("rst_issue_valid", issue_valid, 1'b0);
        chk("rst_fifo_count", fifo_count, 3'd0);
        chk("rst_byte_ready", byte_ready, 1'b1);
        chk("rst_key", key, 32'h0);
        rst_n = 1'b1;
        w_rst_n = 1'b1;
        @(negedge tick_in);
        issue_ready = 1'b1;
        send_frame(8'hA2, 32'h11223344, 32'h55667788);
        @(negedge tick_in);
        chk("wr_signal", signal, 2'd2);
        chk("wr_kind", transact_kind, 1'b1);
        chk("wr_key", key, 32'h11223344);
        chk("wr_value", transact_value, 32'h55667788);
        @(negedge tick_in);
        chk("wr_popped", signal, 2'd0);
        send_frame(8'hA1, 32'hDEADBEEF, 32'h0);
        @(negedge tick_in);
        chk("rd_signal", signal, 2'd1);
        chk("rd_kind", transact_kind, 1'b0);
        chk("rd_key", key, 32'hDEADBEEF);
        chk("rd_value", transact_value, 32'h0);
        @(negedge tick_in);
        issue_ready = 1'b0;
        send_byte(8'h7F, 0);
        byte_valid = 1'b0;
        chk("bad_pulse", bad_hdr, 1'b1);
        @(negedge tick_in);
        chk("bad_clear", bad_hdr, 1'b0);
        send_frame(8'hA2, 32'h01020304, 32'h05060708);
        @(negedge tick_in);
        chk("bad_next_count", fifo_count, 3'd1);
        chk("bad_next_key", key, 32'h01020304);
        issue_ready = 1'b1;
        @(negedge tick_in);
        issue_ready = 1'b0;
        chk("drain1", fifo_count, 3'd0);
        for (int i = 0; i < 5; i++) send_frame(8'hA2, 32'h100 + i, 32'h200 + i);
        repeat (2) @(negedge tick_in);
        chk("full_count", fifo_count, 3'd4);
        chk("full_byte_ready", byte_ready, 1'b0);
        chk("full_head", key, 32'h100);
        issue_ready = 1'b1;
        @(negedge tick_in);
        issue_ready = 1'b0;
        chk("full_pop_count", fifo_count, 3'd3);
        @(negedge tick_in);
        chk("full_push_count", fifo_count, 3'd4);
        chk("full_ready_back", byte_ready, 1'b1);
        for (int i = 1; i < 5; i++) begin
            chk("order_key", key, 32'h100 + i);
            issue_ready = 1'b1;
            @(negedge tick_in);
        end
        issue_ready = 1'b0;
        chk("order_empty", fifo_count, 3'd0);
        send_frame(8'hA1, 32'hAAAA0001, 32'h0);
        send_frame(8'hA1, 32'hAAAA0002, 32'h0);
        send_byte(8'hA2, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i), 0);
        byte_valid = 1'b0;
        chk("pre_rst_count", fifo_count, 3'd2);
        rst_n = 1'b0;
        @(negedge tick_in);
        rst_n = 1'b1;
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_valid", issue_valid, 1'b0);
        issue_ready = 1'b1;
        send_frame(8'hA1, 32'hCAFEBABE, 32'h0);
        @(negedge tick_in);
        chk("post_rst_key", key, 32'hCAFEBABE);
        chk("post_rst_signal", signal, 2'd1);
        @(negedge tick_in);
        issue_ready = 1'b0;
        for (int g = 0; g < 2; g++) begin
            wsend_frame(8'hA2, 64'h0102030405060708, 16'h9ABC, g * 3);
            @(negedge tick_in);
            chk("w_signal", w_signal, 2'd2);
            chk("w_key", w_key, 64'h0102030405060708);
            chk("w_value", w_value, 16'h9ABC);
            w_issue_ready = 1'b1;
            @(negedge tick_in);
            w_issue_ready = 1'b0;
            chk("w_drain", w_fifo_count, 3'd0);
        end
        wsend_frame(8'hA1, 64'hF0E1D2C3B4A59687, 16'h0, 3);
        @(negedge tick_in);
        chk("w_rd_signal", w_signal, 2'd1);
        chk("w_rd_key", w_key, 64'hF0E1D2C3B4A59687);
        chk("w_rd_value", w_value, 16'h0);
        chk("w_bad", w_bad_hdr, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
